// File: rtl/comp_bitstream_mux.sv
// Merges per-component JPEG bitstreams (Y, Cb, Cr) into one word stream, one whole block per channel in turn.
// Optional macro COMP_MUX_SKIP_EMPTY_EN: swallow empty end-of-block entries without an output beat.
module comp_bitstream_mux #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 32,
  parameter int ORC_W      = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*DATA_W-1:0]      ch_bitstream,
  input  logic [NUM_CH-1:0]             ch_data_ready,
  input  logic [NUM_CH-1:0]             ch_block_end,
  input  logic [NUM_CH*ORC_W-1:0]       ch_orc,
  input  logic [NUM_CH-1:0]             ch_eob_empty,
  output logic [DATA_W-1:0]             out_word,
  output logic [5:0]                    out_nbits,
  output logic [$clog2(NUM_CH)-1:0]     out_ch,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   mcu_count,
  output logic [NUM_CH-1:0]             overflow
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 7;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic [15:0]         mcu_q, mcu_d;
  logic [EW-1:0]       head [NUM_CH];
  logic [NUM_CH-1:0]   not_empty;
  logic [NUM_CH-1:0]   pop;
  logic [EW-1:0]       head_cur;
  logic [5:0]          head_nbits;
  logic                head_last;
  logic                cur_ne;
  logic                skip;
  logic                hs;
  logic                pop_any;

  // Entry layout: {word, nbits[5:0], last}
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [EW-1:0]     pend_ent_q, pend_ent_d;
    logic              ovf_q;
    logic [DATA_W-1:0] slice;
    logic [ORC_W-1:0]  orc;
    logic [5:0]        res_nbits;
    logic [EW-1:0]     data_ent, end_ent, push_ent;
    logic              want, collide, accept;

    assign slice     = ch_bitstream[gi*DATA_W +: DATA_W];
    assign orc       = ch_orc[gi*ORC_W +: ORC_W];
    assign res_nbits = (orc == '0) ? 6'(DATA_W) : 6'(orc);
    assign data_ent  = {slice, 6'(DATA_W), 1'b0};
    assign end_ent   = ch_eob_empty[gi] ? {{DATA_W{1'b0}}, 6'd0, 1'b1} : {slice, res_nbits, 1'b1};

    // A latched block-end entry owns the push port for one cycle; anything else arriving then is lost.
    always_comb begin
      want       = 1'b0;
      collide    = 1'b0;
      push_ent   = data_ent;
      pend_d     = pend_q;
      pend_ent_d = pend_ent_q;
      if (pend_q) begin
        want     = 1'b1;
        push_ent = pend_ent_q;
        pend_d   = 1'b0;
        collide  = ch_data_ready[gi] | ch_block_end[gi];
      end else if (ch_data_ready[gi]) begin
        want = 1'b1;
        if (ch_block_end[gi]) begin
          pend_d     = 1'b1;
          pend_ent_d = end_ent;
        end
      end else if (ch_block_end[gi]) begin
        want     = 1'b1;
        push_ent = end_ent;
      end
    end

    assign accept = want & ((cnt_q != (AW+1)'(FIFO_DEPTH)) | pop[gi]);

    always_comb begin
      case ({accept, pop[gi]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
        pend_ent_q <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (accept)  wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q      <= cnt_d;
        pend_q     <= pend_d;
        pend_ent_q <= pend_ent_d;
        ovf_q      <= ovf_q | collide | (want & ~accept);
      end
    end

    always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr_q] <= push_ent;
    end

    assign head[gi]      = mem[rd_ptr_q];
    assign not_empty[gi] = (cnt_q != '0);
    assign overflow[gi]  = ovf_q;
  end

  assign head_cur   = head[cur_q];
  assign head_nbits = head_cur[6:1];
  assign head_last  = head_cur[0];
  assign cur_ne     = not_empty[cur_q];

`ifdef COMP_MUX_SKIP_EMPTY_EN
  assign skip = (state_q == DRAIN) & cur_ne & head_last & (head_nbits == 6'd0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    mcu_d     = mcu_q;
    pop       = '0;
    out_valid = (state_q == DRAIN) & cur_ne & ~skip;
    hs        = out_valid & out_ready;
    pop_any   = hs | skip;
    pop[cur_q] = pop_any;
    case (state_q)
      IDLE:    if (cur_ne) state_d = DRAIN;
      DRAIN:   if (!cur_ne && !hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (pop_any && head_last) begin
      cur_d = (cur_q == CW'(NUM_CH-1)) ? '0 : cur_q + 1'b1;
      if (cur_q == CW'(NUM_CH-1)) mcu_d = mcu_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      mcu_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mcu_q   <= mcu_d;
    end
  end

  // Gating on out_valid keeps every output at zero while idle or in reset.
  assign out_word  = out_valid ? head_cur[EW-1:7] : '0;
  assign out_nbits = out_valid ? head_nbits : 6'd0;
  assign out_last  = out_valid & head_last;
  assign out_ch    = out_valid ? cur_q : '0;
  assign mcu_count = mcu_q;

endmodule

// File: tb/tb_comp_bitstream_mux.sv
// Directed and randomized checks of comp_bitstream_mux against a queue-based model of the channel FIFOs.
module tb_comp_bitstream_mux;
  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  n;
    logic        l;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [95:0] bs;
  logic [2:0]  dr, be, eob;
  logic [14:0] orc;
  logic [31:0] out_word;
  logic [5:0]  out_nbits;
  logic [1:0]  out_ch;
  logic        out_last, out_valid, out_ready;
  logic [15:0] mcu_count;
  logic [2:0]  overflow;

  int checks = 0;
  int errors = 0;

  ent_t        mq [3][$];
  logic [2:0]  pend;
  ent_t        pend_e [3];
  int          mcur;
  logic [15:0] mmcu;
  logic [2:0]  movf;
  ent_t        blog [$];
  int          bch [$];

  comp_bitstream_mux dut (
    .clk(clk), .rst(rst),
    .ch_bitstream(bs), .ch_data_ready(dr), .ch_block_end(be),
    .ch_orc(orc), .ch_eob_empty(eob),
    .out_word(out_word), .out_nbits(out_nbits), .out_ch(out_ch),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .mcu_count(mcu_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) mq[c].delete();
    pend = '0;
    mcur = 0;
    mmcu = '0;
    movf = '0;
  endtask

  task automatic mpush(input int c, input ent_t e);
    if (mq[c].size() < 8) mq[c].push_back(e);
    else movf[c] = 1'b1;
  endtask

  task automatic model_pop(output ent_t e);
    e = mq[mcur].pop_front();
    if (e.l) begin
      if (mcur == 2) mmcu = mmcu + 16'd1;
      mcur = (mcur + 1) % 3;
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model with this cycle's inputs, then clear strobes.
  task automatic tick();
    ent_t        e, de, ee;
    logic [31:0] sl;
    logic [4:0]  o;
    logic [5:0]  nb;
    int          pc;
    @(negedge clk);
    if (out_valid) begin
      chk("valid_has_entry", 64'(mq[mcur].size() != 0), 64'd1);
      if (mq[mcur].size() != 0) begin
        e = mq[mcur][0];
        chk("beat_ch", 64'(out_ch), 64'(mcur));
        chk("beat_word", 64'(out_word), 64'(e.w));
        chk("beat_nbits", 64'(out_nbits), 64'(e.n));
        chk("beat_last", 64'(out_last), 64'(e.l));
      end
    end
    if (out_valid && out_ready && mq[mcur].size() != 0) begin
      pc = mcur;
      model_pop(e);
      blog.push_back(e);
      bch.push_back(pc);
    end
`ifdef COMP_MUX_SKIP_EMPTY_EN
    else if (!out_valid && mq[mcur].size() != 0 && mq[mcur][0].n == 6'd0 && mq[mcur][0].l) begin
      model_pop(e);
    end
`endif
    for (int c = 0; c < 3; c++) begin
      sl = bs[c*32 +: 32];
      o  = orc[c*5 +: 5];
      nb = (o == 5'd0) ? 6'd32 : {1'b0, o};
      de = {sl, 6'd32, 1'b0};
      ee = eob[c] ? {32'd0, 6'd0, 1'b1} : {sl, nb, 1'b1};
      if (pend[c]) begin
        if (dr[c] || be[c]) movf[c] = 1'b1;
        mpush(c, pend_e[c]);
        pend[c] = 1'b0;
      end else if (dr[c] && be[c]) begin
        mpush(c, de);
        pend[c]   = 1'b1;
        pend_e[c] = ee;
      end else if (dr[c]) begin
        mpush(c, de);
      end else if (be[c]) begin
        mpush(c, ee);
      end
    end
    @(posedge clk);
    #1;
    dr  = '0;
    be  = '0;
    eob = '0;
  endtask

  task automatic word(input int c, input logic [31:0] w);
    dr[c] = 1'b1;
    bs[c*32 +: 32] = w;
  endtask

  task automatic bend(input int c, input logic [31:0] w, input logic [4:0] o, input logic eb);
    be[c] = 1'b1;
    bs[c*32 +: 32] = w;
    orc[c*5 +: 5] = o;
    eob[c] = eb;
  endtask

  logic [31:0] t2w [7] = '{32'hB0, 32'hB1, 32'hC0, 32'hC1, 32'hC2, 32'hD0, 32'hD1};
  int          t2n [7] = '{32, 3, 32, 32, 32, 32, 1};
  int          t2l [7] = '{0, 1, 0, 0, 1, 0, 1};
  int          t2c [7] = '{0, 0, 1, 1, 1, 2, 2};
  logic [31:0] t1w [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
  int          t1n [4] = '{32, 32, 32, 7};
  int          t1l [4] = '{0, 0, 0, 1};

  initial begin
    int  done;
    rst = 1'b0; bs = '0; dr = '0; be = '0; orc = '0; eob = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_word", 64'(out_word), 64'd0);
    chk("rst_nbits_ch_last", 64'({out_nbits, out_ch, out_last}), 64'd0);
    chk("rst_mcu", 64'(mcu_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst = 1'b1;
    tick();

    // Cb/Cr data waits behind an unfinished Y block, then one full MCU.
    out_ready = 1'b1;
    blog.delete(); bch.delete();
    word(0, 32'hB0); tick();
    word(1, 32'hC0); word(2, 32'hD0); tick();
    word(1, 32'hC1); tick();
    repeat (4) tick();
    chk("no_interleave_beats", 64'(blog.size()), 64'd1);
    bend(0, 32'hB1, 5'd3, 1'b0); tick();
    repeat (6) tick();
    bend(1, 32'hC2, 5'd0, 1'b0); tick();
    bend(2, 32'hD1, 5'd1, 1'b0); tick();
    repeat (8) tick();
    chk("mcu_order_len", 64'(blog.size()), 64'd7);
    if (blog.size() == 7)
      for (int i = 0; i < 7; i++) begin
        chk("mcu_order_word", 64'(blog[i].w), 64'(t2w[i]));
        chk("mcu_order_nbits", 64'(blog[i].n), 64'(t2n[i]));
        chk("mcu_order_last", 64'(blog[i].l), 64'(t2l[i]));
        chk("mcu_order_ch", 64'(bch[i]), 64'(t2c[i]));
      end
    chk("mcu_one", 64'(mcu_count), 64'd1);

    // Latency from first strobe, then a residual word of 7 bits.
    blog.delete(); bch.delete();
    word(0, 32'hA1); tick();
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    word(0, 32'hA2); tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_word", 64'(out_word), 64'hA1);
    word(0, 32'hA3); tick();
    bend(0, 32'hA4, 5'd7, 1'b0); tick();
    repeat (4) tick();
    chk("y_block_len", 64'(blog.size()), 64'd4);
    if (blog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("y_block_word", 64'(blog[i].w), 64'(t1w[i]));
        chk("y_block_nbits", 64'(blog[i].n), 64'(t1n[i]));
        chk("y_block_last", 64'(blog[i].l), 64'(t1l[i]));
      end
    chk("y_block_cur", 64'(dut.cur_q), 64'd1);

    // Empty residual on Cb.
    blog.delete(); bch.delete();
    bend(1, 32'h1234, 5'd0, 1'b1); tick();
    repeat (4) tick();
`ifdef COMP_MUX_SKIP_EMPTY_EN
    chk("eob_skip_beats", 64'(blog.size()), 64'd0);
`else
    chk("eob_beats", 64'(blog.size()), 64'd1);
    if (blog.size() == 1) chk("eob_beat", 64'(blog[0]), 64'({32'd0, 6'd0, 1'b1}));
`endif
    chk("eob_cur", 64'(dut.cur_q), 64'd2);

    // Nine Cr words into an 8-deep FIFO with the sink stalled.
    blog.delete(); bch.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      word(2, 32'hE0 + i); tick();
    end
    chk("ovf_flag", 64'(overflow), 64'b100);
    tick();
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_word", 64'(out_word), 64'hE0);
    out_ready = 1'b1;
    repeat (10) tick();
    chk("ovf_kept_len", 64'(blog.size()), 64'd8);
    if (blog.size() == 8)
      for (int i = 0; i < 8; i++) chk("ovf_kept_word", 64'(blog[i].w), 64'(32'hE0 + i));
    bend(2, 32'hEF, 5'd4, 1'b0); tick();
    repeat (3) tick();
    chk("mcu_two", 64'(mcu_count), 64'd2);
    chk("mcu_two_cur", 64'(dut.cur_q), 64'd0);

    // Same-cycle data and block end on Y.
    blog.delete(); bch.delete();
    word(0, 32'hF0); bend(0, 32'hF0, 5'd12, 1'b0); tick();
    repeat (5) tick();
    chk("dual_len", 64'(blog.size()), 64'd2);
    if (blog.size() == 2) begin
      chk("dual_first", 64'(blog[0]), 64'({32'hF0, 6'd32, 1'b0}));
      chk("dual_second", 64'(blog[1]), 64'({32'hF0, 6'd12, 1'b1}));
    end

    // Push into a full Cb FIFO in the same cycle as a pop.
    blog.delete(); bch.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      word(1, 32'h100 + i); tick();
    end
    out_ready = 1'b1;
    word(1, 32'h108); tick();
    chk("full_pop_push_ovf", 64'(overflow), 64'b100);
    bend(1, 32'h109, 5'd9, 1'b0); tick();
    repeat (12) tick();
    chk("full_pop_push_len", 64'(blog.size()), 64'd10);
    if (blog.size() == 10) chk("full_pop_push_word", 64'(blog[8].w), 64'h108);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 3; c++) begin
        bs[c*32 +: 32] = $urandom;
        orc[c*5 +: 5]  = 5'($urandom_range(0, 31));
        dr[c] = ($urandom_range(0, 3) == 0);
        be[c] = ($urandom_range(0, 15) == 0);
`ifdef COMP_MUX_SKIP_EMPTY_EN
        eob[c] = 1'b0;
`else
        eob[c] = ($urandom_range(0, 7) == 0);
`endif
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Close blocks as needed until everything has drained.
    out_ready = 1'b1;
    done = 0;
    for (int i = 0; i < 3000 && done == 0; i++) begin
      if (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && pend == 3'b000) begin
        done = 1;
      end else begin
        if (mq[mcur].size() == 0 && !pend[mcur]) bend(mcur, $urandom, 5'($urandom_range(0, 31)), 1'b0);
        tick();
      end
    end
    chk("drain_done", 64'(done), 64'd1);
    repeat (3) tick();
    chk("rand_valid_idle", 64'(out_valid), 64'd0);
    chk("rand_mcu", 64'(mcu_count), 64'(mmcu));
    chk("rand_ovf", 64'(overflow), 64'(movf));

    // Reset while a beat is stalled.
    out_ready = 1'b0;
    word(mcur, 32'h77); tick();
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_mcu", 64'(mcu_count), 64'd0);
    chk("mid_rst_cur", 64'(dut.cur_q), 64'd0);
    chk("mid_rst_word", 64'(out_word), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    blog.delete(); bch.delete();
    word(0, 32'h88); tick();
    repeat (3) tick();
    chk("post_rst_len", 64'(blog.size()), 64'd1);
    if (blog.size() == 1) begin
      chk("post_rst_word", 64'(blog[0].w), 64'h88);
      chk("post_rst_ch", 64'(bch[0]), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
